// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Contents: RV32 load/store opcodes and funct3 codes, FSM state enum,
// access-size enum and the funct3 -> size decode helper.
package load_store_unit_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  // Unknown size encodings fall back to a word access.
  function automatic mem_size_e size_from_funct3(input logic [1:0] size_bits);
    case (size_bits)
      2'b00:   return MEM_BYTE;
      2'b01:   return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   offset      in  byte offset within the word (addr[1:0])
//   funct3      in  access size / signedness
//   wdata       in  raw store data (rs2)
//   rdata_word  in  word returned by memory
//   store_be    out byte enables for a store
//   store_wdata out lane-replicated store data
//   load_data   out extracted and extended load result
//   misaligned  out access crosses its natural alignment
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [DWIDTH-1:0] rdata_word,
  output logic [3:0]        store_be,
  output logic [DWIDTH-1:0] store_wdata,
  output logic [DWIDTH-1:0] load_data,
  output logic              misaligned
);

  mem_size_e   size;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        zero_ext;

  assign size     = size_from_funct3(funct3[1:0]);
  assign zero_ext = funct3[2];

  // Select the addressed byte / halfword out of the read word.
  assign lane_b = 8'(rdata_word >> {offset, 3'b000});
  assign lane_h = 16'(rdata_word >> {offset[1], 4'b0000});

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = wdata;
    load_data   = rdata_word;
    misaligned  = 1'b0;
    case (size)
      MEM_BYTE: begin
        store_be    = 4'b0001 << offset;
        store_wdata = {4{wdata[7:0]}};
        load_data   = zero_ext ? DWIDTH'(lane_b)
                               : {{(DWIDTH-8){lane_b[7]}}, lane_b};
      end
      MEM_HALF: begin
        store_be    = offset[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{wdata[15:0]}};
        load_data   = zero_ext ? DWIDTH'(lane_h)
                               : {{(DWIDTH-16){lane_h[15]}}, lane_h};
        misaligned  = offset[0];
      end
      default: begin
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: runs one req/gnt/rvalid transaction per
// request and returns an aligned, extended load result.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start_i               request valid from execute (sampled in IDLE)
//   opcode_i, funct3_i    decoded instruction fields
//   addr_i, wdata_i       effective address, store data
//   busy_o                pipeline stall request
//   done_o, misalign_o    completion pulse and misalignment flag
//   rdata_o               extended load result, held until next done
//   mem_*                 data memory request/response interface
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i
);

  lsu_state_e        state_q, state_d;

  logic [6:0]        opcode_q;
  logic [2:0]        funct3_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;

  logic              take;
  logic [6:0]        cur_opcode;
  logic [2:0]        cur_funct3;
  logic [AWIDTH-1:0] cur_addr;
  logic [DWIDTH-1:0] cur_wdata;
  logic              is_load, is_store, is_ldst;

  logic [3:0]        store_be;
  logic [DWIDTH-1:0] store_wdata;
  logic [DWIDTH-1:0] load_data;
  logic              align_misaligned;
  logic              misaligned;

  logic              done_d, misalign_d, req_d, we_d;
  logic [DWIDTH-1:0] rdata_d, wdata_d;
  logic [AWIDTH-1:0] addr_d;
  logic [3:0]        be_d;

  // Fields of the access being issued: live inputs on the accepting
  // cycle so the registered mem_* outputs are valid on the first REQ cycle.
  assign take       = (state_q == LSU_IDLE) && start_i;
  assign cur_opcode = take ? opcode_i : opcode_q;
  assign cur_funct3 = take ? funct3_i : funct3_q;
  assign cur_addr   = take ? addr_i   : addr_q;
  assign cur_wdata  = take ? wdata_i  : wdata_q;

  assign is_load  = (cur_opcode == OPCODE_LOAD);
  assign is_store = (cur_opcode == OPCODE_STORE);
  assign is_ldst  = is_load || is_store;

  lsu_align #(.DWIDTH(DWIDTH)) u_align (
    .offset      (cur_addr[1:0]),
    .funct3      (cur_funct3),
    .wdata       (cur_wdata),
    .rdata_word  (mem_rdata_i),
    .store_be    (store_be),
    .store_wdata (store_wdata),
    .load_data   (load_data),
    .misaligned  (align_misaligned)
  );

  assign misaligned = is_ldst && align_misaligned;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (start_i) begin
          if (is_ldst && !misaligned) state_d = LSU_REQ;
          else                        state_d = LSU_DONE;
        end
      end
      LSU_REQ: begin
        if (mem_gnt_i) state_d = is_store ? LSU_DONE : LSU_WAIT;
      end
      LSU_WAIT: begin
        if (mem_rvalid_i) state_d = LSU_DONE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, plus the stall.
  always_comb begin
    req_d      = (state_d == LSU_REQ);
    we_d       = req_d && is_store;
    addr_d     = '0;
    be_d       = '0;
    wdata_d    = '0;
    done_d     = (state_d == LSU_DONE);
    misalign_d = take && misaligned;
    rdata_d    = rdata_o;
    if (req_d) begin
      addr_d  = {cur_addr[AWIDTH-1:2], 2'b00};
      be_d    = is_store ? store_be : 4'b1111;
      wdata_d = is_store ? store_wdata : '0;
    end
    if ((state_q == LSU_WAIT) && mem_rvalid_i) rdata_d = load_data;
    else if (misalign_d)                       rdata_d = '0;
    busy_o = !reset && (take || (state_q == LSU_REQ) || (state_q == LSU_WAIT));
  end

  // Output and request-field registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      rdata_o     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      done_o      <= done_d;
      misalign_o  <= misalign_d;
      rdata_o     <= rdata_d;
      mem_req_o   <= req_d;
      mem_we_o    <= we_d;
      mem_addr_o  <= addr_d;
      mem_be_o    <= be_d;
      mem_wdata_o <= wdata_d;
      if (take) begin
        opcode_q <= opcode_i;
        funct3_q <= funct3_i;
        addr_q   <= addr_i;
        wdata_q  <= wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int tests_run = 0;
  int tests_failed = 0;

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one load and plays the memory side; reports the cycle (relative
  // to the start cycle c0) in which done_o was seen, or -1 on timeout.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] word, input int gnt_wait,
                          input int rv_wait, output logic [31:0] rd,
                          output int done_c);
    int  req_cnt;
    int  rv_cnt;
    bit  granted;
    done_c  = -1;
    rd      = '0;
    req_cnt = 0;
    rv_cnt  = 0;
    granted = 0;
    tick();
    start_i  = 1'b1;
    opcode_i = OPCODE_LOAD;
    funct3_i = f3;
    addr_i   = a;
    wdata_i  = '0;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 40; c++) begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (granted) begin
        rv_cnt++;
        if (rv_cnt == rv_wait) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = word;
        end
      end else if (mem_req_o) begin
        if (req_cnt == gnt_wait) begin
          mem_gnt_i = 1'b1;
          granted   = 1'b1;
        end
        req_cnt++;
      end
      @(negedge clk);
      if (done_o) begin
        done_c = c;
        rd     = rdata_o;
        break;
      end
      tick();
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start_i  = 1'b1;
    opcode_i = OPCODE_LOAD;
    funct3_i = F3_LW;
    addr_i   = 32'h0000_0010;
    wdata_i  = 32'h1234_5678;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if ({busy_o, done_o, misalign_o, mem_req_o, mem_we_o} !== 5'b0 ||
        rdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 ||
        mem_wdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b done=%b mis=%b req=%b we=%b rdata=%h addr=%h be=%h wdata=%h, required all 0",
               busy_o, done_o, misalign_o, mem_req_o, mem_we_o, rdata_o, mem_addr_o, mem_be_o, mem_wdata_o);
    end
    tick();
    reset   = 1'b0;
    start_i = 1'b0;
    tick();
    @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: busy=%b req=%b done=%b, required 0 0 0", busy_o, mem_req_o, done_o);
    end
  endtask

  task automatic test_store_byte();
    tick();
    start_i   = 1'b1;
    opcode_i  = OPCODE_STORE;
    funct3_i  = F3_SB;
    addr_i    = 32'h0000_1003;
    wdata_i   = 32'h0000_00A5;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_c0: busy=%b req=%b, required 1 0", busy_o, mem_req_o);
    end
    tick();
    start_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_1000 ||
        mem_be_o !== 4'b1000 || mem_wdata_o !== 32'hA5A5_A5A5 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_c1_request: req=%b we=%b addr=%h be=%b wdata=%h busy=%b done=%b, required 1 1 00001000 1000 a5a5a5a5 1 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o, done_o);
    end
    tick();
    mem_gnt_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || mem_req_o !== 1'b0 || misalign_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_c2_done: done=%b busy=%b req=%b mis=%b, required 1 0 0 0", done_o, busy_o, mem_req_o, misalign_o);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_done_pulse: done=%b, required 0", done_o);
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] rd;
    int          dc;
    run_load(F3_LB, 32'h0000_2002, 32'h12F0_3456, 0, 3, rd, dc);
    tests_run++;
    if (rd !== 32'hFFFF_FFF0 || dc != 5) begin
      tests_failed++;
      $display("FAIL lb_sign: rdata=%h done_cycle=%0d, required fffffff0 5", rd, dc);
    end
    run_load(F3_LBU, 32'h0000_2002, 32'h12F0_3456, 0, 3, rd, dc);
    tests_run++;
    if (rd !== 32'h0000_00F0 || dc != 5) begin
      tests_failed++;
      $display("FAIL lbu_zero: rdata=%h done_cycle=%0d, required 000000f0 5", rd, dc);
    end
    run_load(F3_LHU, 32'h0000_2002, 32'h12F0_3456, 0, 1, rd, dc);
    tests_run++;
    if (rd !== 32'h0000_12F0 || dc != 3) begin
      tests_failed++;
      $display("FAIL lhu_upper: rdata=%h done_cycle=%0d, required 000012f0 3", rd, dc);
    end
    run_load(F3_LH, 32'h0000_2002, 32'h8001_0000, 2, 1, rd, dc);
    tests_run++;
    if (rd !== 32'hFFFF_8001 || dc != 5) begin
      tests_failed++;
      $display("FAIL lh_sign: rdata=%h done_cycle=%0d, required ffff8001 5", rd, dc);
    end
    run_load(F3_LB, 32'h0000_2000, 32'h8080_807F, 0, 1, rd, dc);
    tests_run++;
    if (rd !== 32'h0000_007F || dc != 3) begin
      tests_failed++;
      $display("FAIL lb_positive: rdata=%h done_cycle=%0d, required 0000007f 3", rd, dc);
    end
    run_load(F3_LW, 32'h0000_2000, 32'h12F0_3456, 0, 1, rd, dc);
    tests_run++;
    if (rd !== 32'h12F0_3456 || dc != 3) begin
      tests_failed++;
      $display("FAIL lw_min_latency: rdata=%h done_cycle=%0d, required 12f03456 3", rd, dc);
    end
  endtask

  task automatic test_nop();
    tick();
    start_i  = 1'b1;
    opcode_i = 7'b0110011;
    funct3_i = F3_LW;
    addr_i   = 32'h0000_0003;
    tick();
    start_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b1 || misalign_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== 32'h12F0_3456) begin
      tests_failed++;
      $display("FAIL nop_opcode: done=%b mis=%b req=%b rdata=%h, required 1 0 0 12f03456",
               done_o, misalign_o, mem_req_o, rdata_o);
    end
  endtask

  task automatic test_grant_withheld();
    tick();
    start_i   = 1'b1;
    opcode_i  = OPCODE_STORE;
    funct3_i  = F3_SW;
    addr_i    = 32'h0000_4008;
    wdata_i   = 32'hCAFE_BABE;
    mem_gnt_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start_i      = (k == 3);
      opcode_i     = OPCODE_LOAD;
      addr_i       = 32'h0000_9001;
      mem_rvalid_i = (k == 2);
      mem_rdata_i  = (k == 2) ? 32'h5555_5555 : 32'h0;
      @(negedge clk);
      tests_run++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_4008 ||
          mem_be_o !== 4'hF || mem_wdata_o !== 32'hCAFE_BABE || busy_o !== 1'b1 || done_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL gnt_wait_stable[%0d]: req=%b we=%b addr=%h be=%h wdata=%h busy=%b done=%b, required 1 1 00004008 f cafebabe 1 0",
                 k, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o, done_o);
      end
    end
    tick();
    start_i      = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_gnt_i    = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || rdata_o !== 32'h12F0_3456) begin
      tests_failed++;
      $display("FAIL gnt_late_done: done=%b busy=%b rdata=%h, required 1 0 12f03456", done_o, busy_o, rdata_o);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_while_busy_ignored: req=%b busy=%b done=%b, required 0 0 0", mem_req_o, busy_o, done_o);
    end
  endtask

  task automatic test_misalign();
    tick();
    start_i  = 1'b1;
    opcode_i = OPCODE_LOAD;
    funct3_i = F3_LW;
    addr_i   = 32'h0000_3001;
    tick();
    start_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b1 || misalign_o !== 1'b1 || rdata_o !== 32'h0 || mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_misalign: done=%b mis=%b rdata=%h req=%b busy=%b, required 1 1 0 0 0",
               done_o, misalign_o, rdata_o, mem_req_o, busy_o);
    end
    tick();
    start_i  = 1'b1;
    opcode_i = OPCODE_STORE;
    funct3_i = F3_SH;
    addr_i   = 32'h0000_3001;
    wdata_i  = 32'h0000_BEEF;
    @(negedge clk);
    tests_run++;
    if (misalign_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_one_cycle: mis=%b done=%b, required 0 0", misalign_o, done_o);
    end
    tick();
    start_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b1 || misalign_o !== 1'b1 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL sh_misalign: done=%b mis=%b req=%b we=%b rdata=%h, required 1 1 0 0 0",
               done_o, misalign_o, mem_req_o, mem_we_o, rdata_o);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    int          dc;
    tick();
    start_i   = 1'b1;
    opcode_i  = OPCODE_LOAD;
    funct3_i  = F3_LW;
    addr_i    = 32'h0000_5000;
    mem_gnt_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    mem_gnt_i = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_wait: req=%b busy=%b done=%b, required 0 0 0", mem_req_o, busy_o, done_o);
    end
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    @(negedge clk);
    tests_run++;
    if (rdata_o !== 32'h0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_rvalid_ignored: rdata=%h done=%b, required 0 0", rdata_o, done_o);
    end
    run_load(F3_LW, 32'h0000_5004, 32'h1122_3344, 0, 1, rd, dc);
    tests_run++;
    if (rd !== 32'h1122_3344 || dc != 3) begin
      tests_failed++;
      $display("FAIL recover_after_reset: rdata=%h done_cycle=%0d, required 11223344 3", rd, dc);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start_i      = 1'b0;
    opcode_i     = '0;
    funct3_i     = '0;
    addr_i       = '0;
    wdata_i      = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    test_reset();
    test_store_byte();
    test_load_extend();
    test_nop();
    test_grant_withheld();
    test_misalign();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
